hdb3_encoding: RTL and testbench
================================

HDB3_ENCODING -- requirements
Module: hdb3_encoding

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock; one input bit is sampled per edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 origin_data  input  1  binary source bit, sampled on a rising clk edge when en=1.
REQ-005 en  input  1  input-valid qualifier; en=0 means no source bit that cycle.
REQ-006 encoding_data  output  3  HDB3 symbol code: 000 zero, 001 +1, 010 -1, 011 +B, 100 -B, 101 +V, 110 -V, 111 never driven.
REQ-007 encoding_data_instruction  output  1  output-valid flag; high when encoding_data carries the symbol of a sampled source bit.

Function
REQ-008 All outputs SHALL be registered and change only on a rising clk edge or on reset assertion.
REQ-009 A bit sampled with en=1 at edge k SHALL appear on the outputs, with encoding_data_instruction=1, immediately after edge k+4 (fixed 4-cycle latency).
REQ-010 The pipeline SHALL advance every cycle regardless of en, so bits in flight drain after en falls.
REQ-011 A cycle sampled with en=0 SHALL produce, 4 cycles later, encoding_data=000 and encoding_data_instruction=0.
REQ-012 Each source 1 SHALL be encoded as a mark (+1/-1) whose polarity is opposite to the previous mark (1 or B).
REQ-013 Every run of four consecutive valid zeros SHALL be replaced: the 4th zero becomes V, and the 1st zero becomes B if the number of source 1s since the last V is even, otherwise it stays zero (patterns 000V or B00V).
REQ-014 V polarity SHALL equal the polarity of the immediately preceding mark (1 or B); B polarity SHALL be opposite to the preceding mark.
REQ-015 After a V, the zero-run count SHALL restart at 0 and the count of 1s since the last V SHALL reset to 0; a 5th-8th zero forms a new independent run.
REQ-016 A cycle with en=0 SHALL reset the zero-run count to 0, SHALL keep the mark polarity and the 1s-since-V parity, and SHALL never be tagged B or V.
REQ-017 When encoding_data_instruction=0, encoding_data SHALL be 000.

Reset
REQ-018 While rst=0: encoding_data=000, encoding_data_instruction=0, all pipeline stages cleared to invalid.
REQ-019 While rst=0: the mark-polarity state is set so the first mark after reset is positive, the 1s-since-V count is 0 (even), and the zero-run count is 0.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight bits; no symbol is output for them after release.

Verification
REQ-021 Reset, then en=1 with bits 1,0,0,0,0 -> outputs 4 cycles later: 001, 000, 000, 000, 101 (+1,0,0,0,+V).
REQ-022 Continue with 1,0,0,1,0,0,0,0 -> outputs: 010, 000, 000, 001, 100, 000, 000, 110 (-1,0,0,+1,-B,0,0,-V).
REQ-023 Continue with 1,0,0,0,0, then en=0 -> outputs: 001, 000, 000, 000, 101 (+1,0,0,0,+V); 4 cycles after en falls, encoding_data_instruction=0 and encoding_data=000.
REQ-024 From reset, eight zeros -> outputs: 011, 000, 000, 101, 100, 000, 000, 110 (+B,0,0,+V,-B,0,0,-V).
REQ-025 Bits 0,0,en=0 gap,0,0,0 -> no V is produced across the gap; a V is produced only after four consecutive valid zeros.
REQ-026 rst pulsed low while bits are in flight -> outputs go to 000 with encoding_data_instruction=0 immediately; after release, the next 1 encodes as +1 (001).

Source files
------------

// File: rtl/hdb3_encoding.sv
// HDB3 line encoder: one source bit per qualified cycle and a fixed 4-cycle latency.
// Zero runs are tagged as they enter the pipe; the mark polarity is applied as symbols leave it.
module hdb3_encoding (
    input  logic       clk,
    input  logic       rst,
    input  logic       origin_data,
    input  logic       en,
    output logic [2:0] encoding_data,
    output logic       encoding_data_instruction
);

    typedef enum logic [1:0] {
        TAG_ZERO = 2'd0,
        TAG_ONE  = 2'd1,
        TAG_B    = 2'd2,
        TAG_V    = 2'd3
    } tag_e;

    typedef struct packed {
        logic valid;
        tag_e tag;
    } stage_t;

    stage_t [3:0] pipe_q, pipe_d;
    stage_t       in_stage_s;
    logic         insert_b_s;
    logic [1:0]   zero_cnt_q, zero_cnt_d;
    logic         ones_odd_q, ones_odd_d;
    logic         last_pos_q, last_pos_d;
    logic [2:0]   enc_q, enc_d;
    logic         vld_q, vld_d;

    // Symbol code for a tag, given whether the most recent mark was positive.
    function automatic logic [2:0] symbol_code(input tag_e tag, input logic last_pos);
        logic [2:0] code;
        case (tag)
            TAG_ZERO: code = 3'b000;
            TAG_ONE:  code = last_pos ? 3'b010 : 3'b001;
            TAG_B:    code = last_pos ? 3'b100 : 3'b011;
            TAG_V:    code = last_pos ? 3'b101 : 3'b110;
            default:  code = 3'b000;
        endcase
        return code;
    endfunction

    // Input classification: zero-run counting, V insertion and B back-tagging.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        ones_odd_d = ones_odd_q;
        in_stage_s = '0;
        insert_b_s = 1'b0;
        if (en) begin
            in_stage_s.valid = 1'b1;
            if (origin_data) begin
                in_stage_s.tag = TAG_ONE;
                zero_cnt_d     = 2'd0;
                ones_odd_d     = ~ones_odd_q;
            end else if (zero_cnt_q == 2'd3) begin
                // The first zero of this run sits in stage 2 and moves to stage 3 now.
                in_stage_s.tag = TAG_V;
                zero_cnt_d     = 2'd0;
                ones_odd_d     = 1'b0;
                insert_b_s     = ~ones_odd_q;
            end else begin
                in_stage_s.tag = TAG_ZERO;
                zero_cnt_d     = zero_cnt_q + 2'd1;
            end
        end else begin
            zero_cnt_d = 2'd0;
        end
    end

    // Pipeline shift, with the optional B retag on the oldest zero of a run.
    always_comb begin
        pipe_d[0] = in_stage_s;
        pipe_d[1] = pipe_q[0];
        pipe_d[2] = pipe_q[1];
        if (insert_b_s) begin
            pipe_d[3]     = pipe_q[2];
            pipe_d[3].tag = TAG_B;
        end else begin
            pipe_d[3] = pipe_q[2];
        end
    end

    // Output stage: polarity assignment. V repeats the last mark and does not update it.
    always_comb begin
        enc_d      = 3'b000;
        vld_d      = 1'b0;
        last_pos_d = last_pos_q;
        if (pipe_q[3].valid) begin
            vld_d = 1'b1;
            enc_d = symbol_code(pipe_q[3].tag, last_pos_q);
            if ((pipe_q[3].tag == TAG_ONE) || (pipe_q[3].tag == TAG_B)) begin
                last_pos_d = ~last_pos_q;
            end else begin
                last_pos_d = last_pos_q;
            end
        end else begin
            enc_d = 3'b000;
            vld_d = 1'b0;
        end
    end

    // State registers; last_pos resets low so the first mark comes out positive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q     <= '0;
            zero_cnt_q <= 2'd0;
            ones_odd_q <= 1'b0;
            last_pos_q <= 1'b0;
            enc_q      <= 3'b000;
            vld_q      <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            zero_cnt_q <= zero_cnt_d;
            ones_odd_q <= ones_odd_d;
            last_pos_q <= last_pos_d;
            enc_q      <= enc_d;
            vld_q      <= vld_d;
        end
    end

    assign encoding_data             = enc_q;
    assign encoding_data_instruction = vld_q;

endmodule

// File: tb/tb_hdb3_encoding.sv
// Self-checking bench for hdb3_encoding: directed vector tables, a mid-stream reset
// sequence, and random streams compared against a whole-sequence HDB3 model.
module tb_hdb3_encoding;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       origin_data = 1'b0;
    logic       en = 1'b0;
    logic [2:0] encoding_data;
    logic       encoding_data_instruction;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       din;
        logic [2:0] exp_code;
    } vec_t;

    vec_t tbl[$];

    hdb3_encoding dut (
        .clk                       (clk),
        .rst                       (rst),
        .origin_data               (origin_data),
        .en                        (en),
        .encoding_data             (encoding_data),
        .encoding_data_instruction (encoding_data_instruction)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic d, input logic [2:0] c);
        vec_t v;
        v.en = e;
        v.din = d;
        v.exp_code = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] exp_code, input logic exp_vld);
        checks++;
        if (encoding_data !== exp_code || encoding_data_instruction !== exp_vld) begin
            failures++;
            $display("FAIL %s: got code=%b valid=%b, expected code=%b valid=%b",
                     name, encoding_data, encoding_data_instruction, exp_code, exp_vld);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        origin_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 3'b000, 1'b0);
        rst = 1'b1;
    endtask

    // Reset, then stream the vectors; output after edge i belongs to the input of edge i-4.
    task automatic run_vectors(input string name, input vec_t v[$]);
        do_reset();
        for (int i = 0; i < v.size() + 4; i++) begin
            if (i < v.size()) begin
                en = v[i].en;
                origin_data = v[i].din;
            end else begin
                en = 1'b0;
                origin_data = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 4) check(name, v[i-4].exp_code, v[i-4].en);
            else check(name, 3'b000, 1'b0);
        end
    endtask

    // Whole-sequence HDB3 reference: tag runs first, then walk the marks with a signed polarity.
    function automatic void model(inout vec_t v[$]);
        int tag[];
        int run;
        int ones;
        int last;
        tag = new[v.size()];
        run = 0;
        ones = 0;
        for (int i = 0; i < v.size(); i++) begin
            if (!v[i].en) begin
                tag[i] = -1;
                run = 0;
            end else if (v[i].din) begin
                tag[i] = 1;
                ones++;
                run = 0;
            end else begin
                tag[i] = 0;
                run++;
                if (run == 4) begin
                    tag[i] = 3;
                    if (ones % 2 == 0) tag[i-3] = 2;
                    ones = 0;
                    run = 0;
                end
            end
        end
        last = -1;
        for (int i = 0; i < v.size(); i++) begin
            case (tag[i])
                1: begin last = -last; v[i].exp_code = (last > 0) ? 3'b001 : 3'b010; end
                2: begin last = -last; v[i].exp_code = (last > 0) ? 3'b011 : 3'b100; end
                3: v[i].exp_code = (last > 0) ? 3'b101 : 3'b110;
                default: v[i].exp_code = 3'b000;
            endcase
        end
    endfunction

    initial begin
        // Mark alternation, 000V, B00V and draining after en falls.
        tbl = {};
        tbl.push_back(mk(1'b1, 1'b1, 3'b001)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b101));
        tbl.push_back(mk(1'b1, 1'b1, 3'b010)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b1, 3'b001));
        tbl.push_back(mk(1'b1, 1'b0, 3'b100)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b110));
        tbl.push_back(mk(1'b1, 1'b1, 3'b001)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b101)); tbl.push_back(mk(1'b0, 1'b0, 3'b000));
        run_vectors("seq_marks", tbl);

        // Eight zeros from reset: two independent B00V runs.
        tbl = {};
        tbl.push_back(mk(1'b1, 1'b0, 3'b011)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b101));
        tbl.push_back(mk(1'b1, 1'b0, 3'b100)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b110));
        run_vectors("eight_zeros", tbl);

        // en=0 gap breaks a zero run; then V does not move the polarity for the next 1.
        tbl = {};
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b0, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b011)); tbl.push_back(mk(1'b1, 1'b0, 3'b000));
        tbl.push_back(mk(1'b1, 1'b0, 3'b000)); tbl.push_back(mk(1'b1, 1'b0, 3'b101));
        tbl.push_back(mk(1'b1, 1'b1, 3'b010));
        run_vectors("gap_run", tbl);

        // Reset asserted while bits are in flight.
        do_reset();
        en = 1'b1;
        origin_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_out", 3'b001, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 3'b000, 1'b0);
        en = 1'b0;
        origin_data = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("flushed_after_reset", 3'b000, 1'b0);
        end
        en = 1'b1;
        origin_data = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        origin_data = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("first_mark_after_reset", 3'b001, 1'b1);

        // Random streams, zero-heavy so substitutions happen often.
        for (int r = 0; r < 4; r++) begin
            tbl = {};
            for (int i = 0; i < 300; i++) begin
                tbl.push_back(mk(($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0,
                                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 3'b000));
            end
            model(tbl);
            run_vectors("random", tbl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
